// File: rtl/bbox_pkg.sv
// Shared types and helpers for the motion bounding-box tracker.
// Holds the tracker FSM encoding, RGB565 colour constants and a clog2 helper.
package bbox_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    // Smallest r with 2**r >= value; elaboration-time use only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_xy_counter.sv
// Pixel/line position counters for one DVP-style stream, saturating at all-ones,
// with a flag telling whether the current position lies inside the active image.
module stream_xy_counter #(
    parameter int MAX_H = 640,
    parameter int MAX_V = 480,
    parameter int CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic          de,
    output logic [CW-1:0] h,
    output logic [CW-1:0] v,
    output logic          in_range
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW:0]   H_LIM   = (CW+1)'(MAX_H);
    localparam logic [CW:0]   V_LIM   = (CW+1)'(MAX_V);

    logic href_d;

    // h/v hold the coordinate of the pixel presented in the current cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h      <= '0;
            v      <= '0;
            href_d <= 1'b0;
        end else begin
            href_d <= href;
            if (!href)
                h <= '0;
            else if (de && h != CNT_MAX)
                h <= h + ONE;
            if (!vsync)
                v <= '0;
            else if (href_d && !href && v != CNT_MAX)
                v <= v + ONE;
        end
    end

    assign in_range = ({1'b0, h} < H_LIM) && ({1'b0, v} < V_LIM);

endmodule

// File: rtl/bbox_tracker.sv
// Tracks the bounding box of motion pixels per mask frame and overlays a
// border (plus optional centre marker) onto the camera stream.
module bbox_tracker
    import bbox_pkg::*;
#(
    parameter int          IMG_W       = 640,
    parameter int          IMG_H       = 480,
    parameter int          BOX_THICK   = 3,
    parameter int          MIN_PIX     = 16,
    parameter int          HOLD_FRAMES = 4,
    parameter logic [15:0] BOX_COLOR   = RGB565_RED,
    parameter int          CROSS_EN    = 1,
    localparam int         CW          = clog2((IMG_W > IMG_H) ? IMG_W : IMG_H),
    localparam int         PW          = clog2(IMG_W * IMG_H + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mask_vsync,
    input  logic          mask_href,
    input  logic          mask_de,
    input  logic          mask_bit,
    input  logic          vid_vsync,
    input  logic          vid_href,
    input  logic          vid_de,
    input  logic [15:0]   vid_data,
    output logic          out_vsync,
    output logic          out_href,
    output logic          out_de,
    output logic [15:0]   out_data,
    output logic [CW-1:0] box_left,
    output logic [CW-1:0] box_right,
    output logic [CW-1:0] box_top,
    output logic [CW-1:0] box_bottom,
    output logic [CW-1:0] box_cx,
    output logic [CW-1:0] box_cy,
    output logic          box_valid,
    output logic [PW-1:0] box_pix,
    output logic [1:0]    dbg_state
);

    localparam logic [CW-1:0] LEFT_INIT = CW'(IMG_W - 1);
    localparam logic [CW-1:0] TOP_INIT  = CW'(IMG_H - 1);
    localparam logic [PW-1:0] MIN_CNT   = PW'(MIN_PIX);
    localparam logic [PW-1:0] PIX_ONE   = PW'(1);
    localparam logic [3:0]    HOLD_CNT  = 4'(HOLD_FRAMES);
    localparam logic [CW:0]   W_MAX     = (CW+1)'(IMG_W - 1);
    localparam logic [CW:0]   H_MAX     = (CW+1)'(IMG_H - 1);
    localparam logic [CW:0]   THICK_M1  = (CW+1)'(BOX_THICK - 1);
    localparam logic [CW:0]   ONE_W     = (CW+1)'(1);

    state_t        state, state_nxt;
    logic [CW-1:0] mh, mv, vh, vv;
    logic          m_in, v_in;
    logic          mask_vsync_d;
    logic          m_rise, m_fall;
    logic [CW-1:0] acc_left, acc_right, acc_top, acc_bottom;
    logic [PW-1:0] pixcnt;
    logic [3:0]    miss_cnt, miss_inc;
    logic [CW:0]   cx_sum, cy_sum;

    stream_xy_counter #(.MAX_H(IMG_W), .MAX_V(IMG_H), .CW(CW)) u_mask_xy (
        .clk(clk), .rst(rst), .vsync(mask_vsync), .href(mask_href), .de(mask_de),
        .h(mh), .v(mv), .in_range(m_in)
    );

    stream_xy_counter #(.MAX_H(IMG_W), .MAX_V(IMG_H), .CW(CW)) u_vid_xy (
        .clk(clk), .rst(rst), .vsync(vid_vsync), .href(vid_href), .de(vid_de),
        .h(vh), .v(vv), .in_range(v_in)
    );

    // Edge history resets high so a frame already in flight at reset release is skipped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_vsync_d <= 1'b1;
        else     mask_vsync_d <= mask_vsync;
    end

    assign m_rise    = mask_vsync && !mask_vsync_d;
    assign m_fall    = !mask_vsync && mask_vsync_d;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_IDLE;
            S_SCAN:   if (m_fall) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (m_rise) state_nxt = S_SCAN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_left   <= '0;
            acc_right  <= '0;
            acc_top    <= '0;
            acc_bottom <= '0;
            pixcnt     <= '0;
        end else if (m_rise) begin
            acc_left   <= LEFT_INIT;
            acc_right  <= '0;
            acc_top    <= TOP_INIT;
            acc_bottom <= '0;
            pixcnt     <= '0;
        end else if (state == S_SCAN && mask_de && mask_bit && m_in) begin
            if (mh < acc_left)   acc_left   <= mh;
            if (mh > acc_right)  acc_right  <= mh;
            if (mv < acc_top)    acc_top    <= mv;
            if (mv > acc_bottom) acc_bottom <= mv;
            if (pixcnt != '1)    pixcnt     <= pixcnt + PIX_ONE;
        end
    end

    assign cx_sum   = {1'b0, acc_left} + {1'b0, acc_right};
    assign cy_sum   = {1'b0, acc_top} + {1'b0, acc_bottom};
    assign miss_inc = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;

    // Box registers only move in the commit cycle, so overlay sees one box per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_left   <= '0;
            box_right  <= '0;
            box_top    <= '0;
            box_bottom <= '0;
            box_cx     <= '0;
            box_cy     <= '0;
            box_pix    <= '0;
            box_valid  <= 1'b0;
            miss_cnt   <= HOLD_CNT;
        end else if (state == S_COMMIT) begin
            if (pixcnt >= MIN_CNT) begin
                box_left   <= acc_left;
                box_right  <= acc_right;
                box_top    <= acc_top;
                box_bottom <= acc_bottom;
                box_cx     <= cx_sum[CW:1];
                box_cy     <= cy_sum[CW:1];
                box_pix    <= pixcnt;
                box_valid  <= 1'b1;
                miss_cnt   <= '0;
            end else begin
                miss_cnt <= miss_inc;
                if (miss_inc >= HOLD_CNT) box_valid <= 1'b0;
            end
        end
    end

    function automatic logic [CW:0] band_end(input logic [CW-1:0] start, input logic [CW:0] lim);
        logic [CW:0] e;
        e = {1'b0, start} + THICK_M1;
        return (e > lim) ? lim : e;
    endfunction

    logic [CW:0] hx, vy, l0, l1, r0, r1, t0, t1, b0, b1, cx, cy;
    logic        in_rows, in_cols, on_band, on_cross;

    assign hx = {1'b0, vh};
    assign vy = {1'b0, vv};
    assign l0 = {1'b0, box_left};
    assign r0 = {1'b0, box_right};
    assign t0 = {1'b0, box_top};
    assign b0 = {1'b0, box_bottom};
    assign l1 = band_end(box_left, W_MAX);
    assign r1 = band_end(box_right, W_MAX);
    assign t1 = band_end(box_top, H_MAX);
    assign b1 = band_end(box_bottom, H_MAX);
    assign cx = {1'b0, box_cx};
    assign cy = {1'b0, box_cy};

    assign in_rows  = (vy >= t0) && (vy <= b0);
    assign in_cols  = (hx >= l0) && (hx <= r0);
    assign on_band  = (in_rows && ((hx >= l0 && hx <= l1) || (hx >= r0 && hx <= r1))) ||
                      (in_cols && ((vy >= t0 && vy <= t1) || (vy >= b0 && vy <= b1)));
    assign on_cross = (CROSS_EN != 0) && (hx + ONE_W >= cx) && (hx <= cx + ONE_W) &&
                      (vy + ONE_W >= cy) && (vy <= cy + ONE_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vsync <= 1'b0;
            out_href  <= 1'b0;
            out_de    <= 1'b0;
            out_data  <= '0;
        end else begin
            out_vsync <= vid_vsync;
            out_href  <= vid_href;
            out_de    <= vid_de;
            if (!vid_de)
                out_data <= '0;
            else if (box_valid && v_in && (on_band || on_cross))
                out_data <= BOX_COLOR;
            else
                out_data <= vid_data;
        end
    end

endmodule

// File: tb/tb_bbox_tracker.sv
// Directed bench for bbox_tracker: mask frames with known rectangles, then
// video frames whose overlay is checked at hand-picked coordinates.
module tb_bbox_tracker;
    import bbox_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mask_vsync = 0, mask_href = 0, mask_de = 0, mask_bit = 0;
    logic        vid_vsync = 0, vid_href = 0, vid_de = 0;
    logic [15:0] vid_data = '0;
    logic        out_vsync, out_href, out_de;
    logic [15:0] out_data;
    logic [9:0]  box_left, box_right, box_top, box_bottom, box_cx, box_cy;
    logic        box_valid;
    logic [18:0] box_pix;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] cap [int];

    bbox_tracker dut (
        .clk(clk), .rst(rst),
        .mask_vsync(mask_vsync), .mask_href(mask_href), .mask_de(mask_de), .mask_bit(mask_bit),
        .vid_vsync(vid_vsync), .vid_href(vid_href), .vid_de(vid_de), .vid_data(vid_data),
        .out_vsync(out_vsync), .out_href(out_href), .out_de(out_de), .out_data(out_data),
        .box_left(box_left), .box_right(box_right), .box_top(box_top), .box_bottom(box_bottom),
        .box_cx(box_cx), .box_cy(box_cy), .box_valid(box_valid), .box_pix(box_pix),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [15:0] pat(input int h, input int v);
        return 16'(32'h0100 + h + v);
    endfunction

    task automatic pulse_reset_mid();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", box_valid, 0);
        check("mid_rst_left", box_left, 0);
        check("mid_rst_right", box_right, 0);
        check("mid_rst_pix", box_pix, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_state", dbg_state, S_IDLE);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Lines inside [bt,bb] carry len pixels; mask ones fill [bl,br]x[bt,bb].
    task automatic mask_frame(input int n_lines, input int bl, input int br,
                              input int bt, input int bb, input int len, input int rst_line);
        @(negedge clk);
        mask_vsync = 1'b1;
        repeat (2) @(negedge clk);
        for (int v = 0; v < n_lines; v++) begin
            if (v == rst_line) pulse_reset_mid();
            mask_href = 1'b1;
            if (v >= bt && v <= bb) begin
                for (int h = 0; h < len; h++) begin
                    mask_de  = 1'b1;
                    mask_bit = (h >= bl && h <= br);
                    @(negedge clk);
                end
            end
            mask_de  = 1'b0;
            mask_bit = 1'b0;
            @(negedge clk);
            mask_href = 1'b0;
            @(negedge clk);
        end
        mask_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Row 0 and rows v_lo..v_hi carry len pixels; each output pixel is captured.
    task automatic vid_frame(input int n_lines, input int v_lo, input int v_hi, input int len);
        cap.delete();
        @(negedge clk);
        vid_vsync = 1'b1;
        repeat (2) @(negedge clk);
        for (int v = 0; v < n_lines; v++) begin
            vid_href = 1'b1;
            if ((v >= v_lo && v <= v_hi) || v == 0) begin
                for (int h = 0; h < len; h++) begin
                    vid_de   = 1'b1;
                    vid_data = pat(h, v);
                    @(posedge clk);
                    #1;
                    cap[v * 1024 + h] = out_data;
                    if (v == v_lo && h == 0) begin
                        check("tim_out_de_hi", out_de, 1);
                        check("tim_out_href_hi", out_href, 1);
                        check("tim_out_vsync_hi", out_vsync, 1);
                    end
                    @(negedge clk);
                end
            end
            vid_de   = 1'b0;
            vid_data = 16'h1234;
            @(posedge clk);
            #1;
            if (v == v_lo) begin
                check("tim_out_de_lo", out_de, 0);
                check("tim_out_data_de_lo", out_data, 0);
            end
            @(negedge clk);
            vid_href = 1'b0;
            @(negedge clk);
        end
        vid_vsync = 1'b0;
        @(posedge clk);
        #1;
        check("tim_out_vsync_lo", out_vsync, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_pix(input string tag, input int h, input int v, input bit colored);
        logic [31:0] got;
        got = cap.exists(v * 1024 + h) ? {16'h0, cap[v * 1024 + h]} : 32'hDEADBEEF;
        check(tag, got, colored ? 32'h0000F800 : {16'h0, pat(h, v)});
    endtask

    task automatic chk_box(input string tag, input int l, input int r, input int t, input int b,
                           input int cx, input int cy, input int pix, input int valid);
        check({tag, "_left"}, box_left, l);
        check({tag, "_right"}, box_right, r);
        check({tag, "_top"}, box_top, t);
        check({tag, "_bottom"}, box_bottom, b);
        check({tag, "_cx"}, box_cx, cx);
        check({tag, "_cy"}, box_cy, cy);
        check({tag, "_pix"}, box_pix, pix);
        check({tag, "_valid"}, box_valid, valid);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_box("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_de", out_de, 0);
        check("reset_state", dbg_state, S_IDLE);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Rectangle 100..149 x 50..89 -> 2000 pixels
        mask_frame(90, 100, 149, 50, 89, 150, -1);
        chk_box("rect", 100, 149, 50, 89, 124, 69, 2000, 1);
        check("rect_state", dbg_state, S_IDLE);

        vid_frame(71, 59, 70, 156);
        chk_pix("ov_l100", 100, 60, 1);
        chk_pix("ov_l101", 101, 60, 1);
        chk_pix("ov_l102", 102, 60, 1);
        chk_pix("ov_centre", 124, 69, 1);
        chk_pix("ov_cross_diag", 123, 68, 1);
        chk_pix("ov_r149", 149, 70, 1);
        chk_pix("ov_r150", 150, 70, 1);
        chk_pix("ov_r151", 151, 70, 1);
        chk_pix("pass_h99", 99, 60, 0);
        chk_pix("pass_h152", 152, 70, 0);
        chk_pix("pass_h153", 153, 70, 0);
        chk_pix("pass_h126", 126, 69, 0);
        chk_pix("pass_row0", 100, 0, 0);

        // Four weak frames of 10 pixels each
        for (int k = 1; k <= 4; k++) begin
            mask_frame(6, 10, 19, 5, 5, 20, -1);
            check($sformatf("miss%0d_valid", k), box_valid, (k < 4) ? 1 : 0);
            check($sformatf("miss%0d_left", k), box_left, 100);
            check($sformatf("miss%0d_pix", k), box_pix, 2000);
        end
        vid_frame(61, 60, 60, 104);
        chk_pix("novalid_l100", 100, 60, 0);
        chk_pix("novalid_l101", 101, 60, 0);

        // Edge box with mask ones beyond the image that must be ignored
        mask_frame(481, 620, 644, 478, 480, 645, -1);
        chk_box("edge", 620, 639, 478, 479, 629, 478, 40, 1);
        vid_frame(480, 477, 479, 640);
        chk_pix("edge_br", 639, 479, 1);
        chk_pix("edge_r478", 639, 478, 1);
        chk_pix("edge_bot625", 625, 479, 1);
        chk_pix("edge_left621", 621, 478, 1);
        chk_pix("edge_cross477", 629, 477, 1);
        chk_pix("edge_pass619", 619, 479, 0);
        chk_pix("edge_pass626_477", 626, 477, 0);
        chk_pix("edge_pass639_477", 639, 477, 0);
        chk_pix("edge_nowrap_h0", 0, 479, 0);
        chk_pix("edge_nowrap_v0", 0, 0, 0);
        chk_pix("edge_nowrap_630_0", 630, 0, 0);
        chk_pix("edge_nowrap_639_0", 639, 0, 0);

        // Reset at v=200 discards the frame
        mask_frame(251, 10, 29, 150, 250, 30, 200);
        chk_box("aborted", 0, 0, 0, 0, 0, 0, 0, 0);
        check("aborted_state", dbg_state, S_IDLE);

        mask_frame(110, 10, 29, 100, 109, 30, -1);
        chk_box("recover", 10, 29, 100, 109, 19, 104, 200, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
